serial_link_supervisor: RTL and testbench

- Supervises one serial receiver instance (32-word, CRC-16 frame receiver) and sequences its recovery.
- Watches `receive_done` and `errors_count` to classify each frame as good or bad, and runs a frame watchdog.
- Drives the receiver's `reset` to resynchronise after link loss.
- Publishes link status, a per-frame strobe and statistics to the vector-control core.

---
 rtl/serial_link_pkg.sv | 14 +
 rtl/serial_rx_event_det.sv | 35 +++
 rtl/serial_link_supervisor.sv | 88 ++++++++
 tb/tb_serial_link_supervisor.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared constants and state encoding for the serial link supervisor.
package serial_link_pkg;
    localparam int ERR_W = 16;
    localparam int DEF_TIMEOUT_CYC = 100000;
    localparam int DEF_SYNC_FRAMES = 4;
    localparam int DEF_MAX_ERR = 8;
    localparam int DEF_RST_CYCLES = 16;
    typedef enum logic [1:0] {
        ST_RESET_RX  = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_LINKED    = 2'd2,
        ST_LOST      = 2'd3
    } link_state_t;
endpackage

// File: rtl/serial_rx_event_det.sv
// serial_rx_event_det: resynchronises receiver status and turns it into good/error frame events.
module serial_rx_event_det
    import serial_link_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             track,
    input  logic             receive_done,
    input  logic [ERR_W-1:0] errors_count,
    output logic             good_ev,
    output logic             err_ev
);
    logic [2:0]       done_q;
    logic [ERR_W-1:0] err_q1, err_q2, err_prev;
    logic             stable;
    // Both stages agreeing hides partial updates of the multi-bit counter.
    assign stable = err_q1 == err_q2;
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q   <= '0;
            err_q1   <= errors_count;
            err_q2   <= errors_count;
            err_prev <= errors_count;
            good_ev  <= 1'b0;
            err_ev   <= 1'b0;
        end else begin
            done_q  <= {done_q[1:0], receive_done};
            err_q1  <= errors_count;
            err_q2  <= err_q1;
            good_ev <= !track && done_q[1] && !done_q[2];
            err_ev  <= !track && stable && (err_q2 != err_prev);
            if (stable) err_prev <= err_q2;
        end
    end
endmodule

// File: rtl/serial_link_supervisor.sv
// serial_link_supervisor: classifies receiver frames, runs the link watchdog and sequences
// receiver resets, publishing link status and statistics.
module serial_link_supervisor
    import serial_link_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int SYNC_FRAMES = DEF_SYNC_FRAMES,
    parameter int MAX_ERR     = DEF_MAX_ERR,
    parameter int RST_CYCLES  = DEF_RST_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             receive_done,
    input  logic [ERR_W-1:0] errors_count,
    output logic             rx_reset,
    output logic             link_ok,
    output logic [1:0]       link_state,
    output logic             frame_strobe,
    output logic [15:0]      good_frames,
    output logic [7:0]       lost_count
);
    localparam int WD_W = $clog2(4 * TIMEOUT_CYC);
    localparam int RC_W = $clog2(RST_CYCLES);
    localparam logic [WD_W-1:0] WD_LINK  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] WD_SYNC  = WD_W'(4 * TIMEOUT_CYC - 1);
    localparam logic [RC_W-1:0] RC_END   = RC_W'(RST_CYCLES - 1);
    localparam logic [7:0]      SYNC_END = 8'(SYNC_FRAMES);
    localparam logic [7:0]      ERR_END  = 8'(MAX_ERR);

    link_state_t     state, state_nxt;
    logic [RC_W-1:0] rst_cnt;
    logic [7:0]      sync_cnt, err_cnt, sync_nxt, err_nxt;
    logic [WD_W-1:0] wd_cnt, wd_inc;
    logic            good_ev, err_ev, good;

    serial_rx_event_det u_det (
        .clk          (clk),
        .reset        (reset),
        .track        (rx_reset),
        .receive_done (receive_done),
        .errors_count (errors_count),
        .good_ev      (good_ev),
        .err_ev       (err_ev)
    );

    // An error in the same cycle as a frame edge wins; the frame is discarded.
    assign good     = good_ev && !err_ev;
    assign wd_inc   = wd_cnt + WD_W'(1);
    assign sync_nxt = err_ev ? 8'd0 : sync_cnt + 8'(good);
    assign err_nxt  = err_cnt + 8'(err_ev);

    assign rx_reset     = state == ST_RESET_RX;
    assign link_ok      = state == ST_LINKED;
    assign link_state   = state;
    assign frame_strobe = link_ok && good;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET_RX:  state_nxt = (rst_cnt == RC_END) ? ST_WAIT_SYNC : ST_RESET_RX;
            ST_WAIT_SYNC: state_nxt = (sync_nxt == SYNC_END) ? ST_LINKED :
                                      (wd_inc == WD_SYNC) ? ST_RESET_RX : ST_WAIT_SYNC;
            ST_LINKED:    state_nxt = (err_nxt == ERR_END || (!good && wd_inc == WD_LINK)) ?
                                      ST_LOST : ST_LINKED;
            default:      state_nxt = ST_RESET_RX;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RESET_RX;
            rst_cnt     <= '0;
            sync_cnt    <= '0;
            err_cnt     <= '0;
            wd_cnt      <= '0;
            good_frames <= '0;
            lost_count  <= '0;
        end else begin
            state       <= state_nxt;
            rst_cnt     <= (rx_reset && state_nxt == ST_RESET_RX) ? rst_cnt + RC_W'(1) : '0;
            sync_cnt    <= (state == ST_WAIT_SYNC && state_nxt == ST_WAIT_SYNC) ? sync_nxt : '0;
            err_cnt     <= (link_ok && state_nxt == ST_LINKED && !good) ? err_nxt : '0;
            wd_cnt      <= (rx_reset || state_nxt != state || frame_strobe) ? '0 : wd_inc;
            good_frames <= good_frames + 16'(frame_strobe);
            lost_count  <= (state == ST_LOST && lost_count != 8'hFF) ? lost_count + 8'd1 : lost_count;
        end
    end
endmodule

// File: tb/tb_serial_link_supervisor.sv
// tb_serial_link_supervisor: vector table plus hand sequences; frame strobes are checked
// against a scoreboard of expected good_frames values.
module tb_serial_link_supervisor;
    logic        clk, reset, receive_done;
    logic [15:0] errors_count;
    logic        rx_reset, link_ok, frame_strobe;
    logic [1:0]  link_state;
    logic [15:0] good_frames;
    logic [7:0]  lost_count;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] sb[$];
    logic [15:0] gf_exp = 16'd0;
    logic [7:0]  exp_lost = 8'd0;
    logic        mon_prev = 1'b0;

    typedef struct packed {
        logic        done;
        logic        chg;
        logic [15:0] err;
        logic        strobe;
        logic [1:0]  st;
    } vec_t;
    vec_t vecs[13];

    serial_link_supervisor #(
        .TIMEOUT_CYC (200),
        .SYNC_FRAMES (3),
        .MAX_ERR     (2),
        .RST_CYCLES  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .receive_done (receive_done),
        .errors_count (errors_count),
        .rx_reset     (rx_reset),
        .link_ok      (link_ok),
        .link_state   (link_state),
        .frame_strobe (frame_strobe),
        .good_frames  (good_frames),
        .lost_count   (lost_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string name);
        int n = 0;
        while (link_state !== s && n < budget) begin
            step(1);
            n++;
        end
        chk(name, 32'(link_state), 32'(s));
    endtask

    task automatic rx_reset_len(input string name);
        int n = 0;
        while (rx_reset && n < 20) begin
            n++;
            step(1);
        end
        chk(name, n, 4);
    endtask

    task automatic sync_up();
        for (int i = 0; i < 3; i++) begin
            receive_done = 1'b1;
            step(2);
            receive_done = 1'b0;
            step(2);
        end
    endtask

    task automatic expect_strobe();
        sb.push_back(gf_exp);
        gf_exp = gf_exp + 16'd1;
    endtask

    // Every strobe must be expected, single-cycle, inside LINKED, with the pre-increment count.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_strobe) begin
                chk("strobe_width", 32'(mon_prev), 0);
                chk("strobe_linked", 32'(link_ok), 1);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual=1 required=0 good_frames=%0d", good_frames);
                end else begin
                    chk("sb_good_frames", 32'(good_frames), 32'(sb.pop_front()));
                end
            end
            mon_prev = frame_strobe;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 5; i++) vecs[i] = '{1'b1, 1'b0, 16'd10, 1'b1, 2'd2};
        vecs[5]  = '{1'b1, 1'b1, 16'd11,     1'b0, 2'd2};
        vecs[6]  = '{1'b1, 1'b0, 16'd11,     1'b1, 2'd2};
        vecs[7]  = '{1'b0, 1'b1, 16'hFFFF,   1'b0, 2'd2};
        vecs[8]  = '{1'b1, 1'b0, 16'hFFFF,   1'b1, 2'd2};
        vecs[9]  = '{1'b0, 1'b1, 16'h0000,   1'b0, 2'd2};
        vecs[10] = '{1'b1, 1'b0, 16'h0000,   1'b1, 2'd2};
        vecs[11] = '{1'b0, 1'b1, 16'd10,     1'b0, 2'd2};
        vecs[12] = '{1'b1, 1'b0, 16'd10,     1'b1, 2'd2};

        reset = 1'b1;
        receive_done = 1'b0;
        errors_count = 16'd10;
        step(3);
        chk("rst_state", 32'(link_state), 0);
        chk("rst_rx_reset", 32'(rx_reset), 1);
        chk("rst_link_ok", 32'(link_ok), 0);
        chk("rst_strobe", 32'(frame_strobe), 0);
        chk("rst_good_frames", 32'(good_frames), 0);
        chk("rst_lost", 32'(lost_count), 0);
        reset = 1'b0;
        rx_reset_len("bringup_rx_reset_len");
        chk("bringup_wait_sync", 32'(link_state), 1);

        for (int i = 0; i < 2; i++) begin
            receive_done = 1'b1;
            step(2);
            receive_done = 1'b0;
            step(38);
        end
        receive_done = 1'b1;
        step(3);
        chk("bringup_not_yet_linked", 32'(link_state), 1);
        step(1);
        chk("bringup_linked", 32'(link_state), 2);
        chk("bringup_link_ok", 32'(link_ok), 1);
        receive_done = 1'b0;
        step(3);
        chk("bringup_good_frames", 32'(good_frames), 0);

        for (int i = 0; i < 13; i++) begin
            receive_done = vecs[i].done;
            if (vecs[i].chg) errors_count = vecs[i].err;
            if (vecs[i].strobe) expect_strobe();
            step(3);
            chk($sformatf("vec%0d_strobe", i), 32'(frame_strobe), 32'(vecs[i].strobe));
            receive_done = 1'b0;
            step(3);
            chk($sformatf("vec%0d_state", i), 32'(link_state), 32'(vecs[i].st));
            if (i == 4) chk("traffic_good_frames", 32'(good_frames), 5);
        end
        chk("table_good_frames", 32'(good_frames), 32'(gf_exp));

        errors_count = 16'd11;
        step(6);
        chk("err1_still_linked", 32'(link_state), 2);
        errors_count = 16'd12;
        step(3);
        chk("err2_event_cycle", 32'(link_state), 2);
        step(1);
        chk("err2_lost", 32'(link_state), 3);
        step(1);
        exp_lost = 8'd1;
        chk("err_lost_count", 32'(lost_count), 32'(exp_lost));
        errors_count = 16'd0;
        rx_reset_len("err_rx_reset_len");
        chk("err_back_to_sync", 32'(link_state), 1);
        sync_up();
        wait_state(2, 10, "resync_linked");

        receive_done = 1'b1;
        expect_strobe();
        step(3);
        receive_done = 1'b0;
        begin
            int n = 0;
            while (link_state == 2'd2 && n < 400) begin
                step(1);
                n++;
            end
            chk("wd_linked_cycles", n, 200);
        end
        chk("wd_linked_lost", 32'(link_state), 3);
        step(1);
        exp_lost = 8'd2;
        chk("wd_lost_count", 32'(lost_count), 32'(exp_lost));

        wait_state(1, 10, "wd_sync_enter");
        begin
            int n = 0;
            while (link_state == 2'd1 && n < 1000) begin
                step(1);
                n++;
            end
            chk("wd_sync_cycles", n, 799);
        end
        chk("wd_sync_reset_rx", 32'(link_state), 0);
        chk("wd_sync_lost_unchanged", 32'(lost_count), 32'(exp_lost));

        for (int i = 0; i < 255; i++) begin
            wait_state(1, 20, "sat_wait_sync");
            sync_up();
            wait_state(2, 10, "sat_linked");
            errors_count = errors_count + 16'd1;
            step(4);
            errors_count = errors_count + 16'd1;
            wait_state(0, 30, "sat_reset_rx");
            exp_lost = (exp_lost == 8'hFF) ? 8'hFF : exp_lost + 8'd1;
            chk($sformatf("sat_lost_%0d", i), 32'(lost_count), 32'(exp_lost));
        end
        chk("sat_hold_255", 32'(lost_count), 255);

        wait_state(1, 20, "mid_wait_sync");
        sync_up();
        wait_state(2, 10, "mid_linked");
        receive_done = 1'b1;
        expect_strobe();
        step(3);
        receive_done = 1'b0;
        step(3);
        chk("mid_good_frames", 32'(good_frames), 32'(gf_exp));
        reset = 1'b1;
        step(1);
        chk("mid_rst_state", 32'(link_state), 0);
        chk("mid_rst_rx_reset", 32'(rx_reset), 1);
        chk("mid_rst_link_ok", 32'(link_ok), 0);
        chk("mid_rst_strobe", 32'(frame_strobe), 0);
        chk("mid_rst_good_frames", 32'(good_frames), 0);
        chk("mid_rst_lost", 32'(lost_count), 0);
        reset = 1'b0;
        rx_reset_len("mid_rx_reset_len");
        step(2);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
